// File: rtl/filt_sequencer.sv
// Address/control sequencer for the LPfilt FIR datapath.
// Samples land in a circular queue; each new sample past TAPS runs one pass.
module filt_sequencer #(
   parameter int TAPS  = 1021,
   parameter int DEPTH = 1536,
   parameter int AW    = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid,
   output logic          wrt_en,
   output logic [AW-1:0] wrt_addr,
   output logic [AW-1:0] rd_addr,
   output logic [AW-1:0] coeff_addr,
   output logic          sequencing,
   output logic          acc_clr,
   output logic          acc_en,
   output logic          out_valid,
   output logic          full,
   output logic          overrun
);

   localparam int CW = AW + 1;
   localparam logic [AW:0]   TAPS_W  = CW'(TAPS);
   localparam logic [AW:0]   DEPTH_W = CW'(DEPTH);
   localparam logic [AW-1:0] LAST_C  = AW'(TAPS - 1);
   localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] new_ptr_q, new_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          pend_q, pend_d;
   logic          overrun_q, overrun_d;
   logic          wrt_en_q, wrt_en_d;
   logic [AW-1:0] wrt_addr_q, wrt_addr_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [AW-1:0] coeff_addr_q, coeff_addr_d;
   logic          seq_q, seq_d;
   logic          acc_clr_q, acc_clr_d;
   logic          acc_en_q, acc_en_d;
   logic          out_valid_q, out_valid_d;

   logic          start;
   logic [AW:0]   ptr_w;
   logic [AW-1:0] start_rd;

   assign full = (count_q >= TAPS_W);

   always_comb begin
      state_d      = state_q;
      new_ptr_d    = new_ptr_q;
      count_d      = count_q;
      pend_d       = pend_q;
      overrun_d    = overrun_q;
      wrt_en_d     = 1'b0;
      wrt_addr_d   = wrt_addr_q;
      rd_addr_d    = rd_addr_q;
      coeff_addr_d = coeff_addr_q;
      seq_d        = seq_q;
      acc_clr_d    = 1'b0;
      acc_en_d     = seq_q;
      out_valid_d  = (state_q == DONE);
      start        = (state_q == IDLE) && ((wrt_en_q && full) || pend_q);
      ptr_w        = {1'b0, new_ptr_q};
      // Oldest of the TAPS newest samples, modulo the queue depth.
      if (ptr_w >= TAPS_W) begin
         start_rd = AW'(ptr_w - TAPS_W);
      end else begin
         start_rd = AW'(ptr_w + DEPTH_W - TAPS_W);
      end

      if (valid) begin
         wrt_en_d   = 1'b1;
         wrt_addr_d = new_ptr_q;
         new_ptr_d  = (new_ptr_q == LAST_A) ? '0 : new_ptr_q + AW'(1);
         if (count_q != DEPTH_W) begin
            count_d = count_q + CW'(1);
         end
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = RUN;
               rd_addr_d    = start_rd;
               coeff_addr_d = '0;
               seq_d        = 1'b1;
               acc_clr_d    = 1'b1;
               pend_d       = 1'b0;
            end
         end
         RUN: begin
            if (coeff_addr_q == LAST_C) begin
               state_d = DONE;
               seq_d   = 1'b0;
            end else begin
               rd_addr_d    = (rd_addr_q == LAST_A) ? '0 : rd_addr_q + AW'(1);
               coeff_addr_d = coeff_addr_q + AW'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A sample that cannot start its own pass now waits as one pending pass.
      if (valid && (state_q != IDLE || start)) begin
         pend_d = 1'b1;
         if (pend_q) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         new_ptr_q    <= '0;
         count_q      <= '0;
         pend_q       <= 1'b0;
         overrun_q    <= 1'b0;
         wrt_en_q     <= 1'b0;
         wrt_addr_q   <= '0;
         rd_addr_q    <= '0;
         coeff_addr_q <= '0;
         seq_q        <= 1'b0;
         acc_clr_q    <= 1'b0;
         acc_en_q     <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         new_ptr_q    <= new_ptr_d;
         count_q      <= count_d;
         pend_q       <= pend_d;
         overrun_q    <= overrun_d;
         wrt_en_q     <= wrt_en_d;
         wrt_addr_q   <= wrt_addr_d;
         rd_addr_q    <= rd_addr_d;
         coeff_addr_q <= coeff_addr_d;
         seq_q        <= seq_d;
         acc_clr_q    <= acc_clr_d;
         acc_en_q     <= acc_en_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign wrt_en     = wrt_en_q;
   assign wrt_addr   = wrt_addr_q;
   assign rd_addr    = rd_addr_q;
   assign coeff_addr = coeff_addr_q;
   assign sequencing = seq_q;
   assign acc_clr    = acc_clr_q;
   assign acc_en     = acc_en_q;
   assign out_valid  = out_valid_q;
   assign overrun    = overrun_q;

endmodule
